// File: rtl/vec_loader_pkg.sv
// Shared types and defaults for the vec_loader front end.
package vec_loader_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 16;
    // Width of the element-count port towards the engine
    localparam int unsigned N_W        = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StStart,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/loader_watchdog.sv
// Loadable down-counter that flags expiry while enabled.
// Only instantiated when VEC_LOADER_TIMEOUT_EN is defined.
module loader_watchdog #(
    parameter int unsigned CntW = 20
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            en_i,
    output logic            expired_o
);

    logic [CntW-1:0] cnt_q;

    // Reload on load_i, otherwise count down towards zero while enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Expired once the count has reached zero within an enabled window
    always_comb begin
        expired_o = en_i && (cnt_q == '0);
    end

endmodule

// File: rtl/vec_loader.sv
// Host-side loader for the dot-product engine: streams (a, b) pairs into the
// vector RAMs via the init port, pulses start with the count, waits for done and
// returns the result on a valid/ready response port.
// Optional watchdog on the WAIT state: define VEC_LOADER_TIMEOUT_EN.
module vec_loader
    import vec_loader_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    input  logic              s_last,
    output logic              ram_init,
    output logic [DATA_W-1:0] a_ram_in,
    output logic [DATA_W-1:0] b_ram_in,
    output logic [ADDR_W-1:0] a_addr_in,
    output logic [ADDR_W-1:0] b_addr_in,
    output logic              start_sig,
    output logic [N_W-1:0]    n,
    input  logic [DATA_W-1:0] result,
    input  logic              done_flag,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_result,
    output logic              m_err
);

    state_e            state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              err_ovf_q;
    logic              ram_init_q;
    logic [DATA_W-1:0] a_ram_q;
    logic [DATA_W-1:0] b_ram_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_q;
    logic [N_W-1:0]    n_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_result_q;
    logic              m_err_q;

    logic              load_state;
    logic              accept;
    logic [ADDR_W-1:0] wr_addr;
    logic              at_max;
    logic              tmo_expired;

    // Beat acceptance, write address and overflow detection
    always_comb begin
        load_state = (state_q == StIdle) || (state_q == StLoad);
        accept     = s_valid && load_state;
        wr_addr    = (state_q == StIdle) ? '0 : count_q[ADDR_W-1:0];
        count_d    = (state_q == StIdle) ? (ADDR_W+1)'(1) : count_q + 1'b1;
        // Last RAM slot reached without s_last: close the vector here
        at_max     = (state_q == StLoad) && (count_q[ADDR_W-1:0] == {ADDR_W{1'b1}});
    end

`ifdef VEC_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // Loaded in START so expiry lands after exactly TIMEOUT_CYC WAIT cycles
    loader_watchdog #(
        .CntW (TmoW)
    ) u_watchdog (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (state_q == StStart),
        .load_val_i (TmoW'(TIMEOUT_CYC - 1)),
        .en_i       (state_q == StWait),
        .expired_o  (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo_expired    = 1'b0;
`endif

    // Main control FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            err_ovf_q  <= 1'b0;
            ram_init_q <= 1'b0;
            a_ram_q    <= '0;
            b_ram_q    <= '0;
            addr_q     <= '0;
            start_q    <= 1'b0;
            n_q        <= '0;
            m_valid_q  <= 1'b0;
            m_result_q <= '0;
            m_err_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                StIdle, StLoad: begin
                    if (accept) begin
                        ram_init_q <= 1'b1;
                        a_ram_q    <= s_a;
                        b_ram_q    <= s_b;
                        addr_q     <= wr_addr;
                        count_q    <= count_d;
                        if (s_last || at_max) begin
                            n_q     <= N_W'(count_d);
                            state_q <= StDrain;
                            if (!s_last) begin
                                err_ovf_q <= 1'b1;
                            end
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StDrain: begin
                    // ram_init stays high through this cycle for the final write
                    ram_init_q <= 1'b0;
                    start_q    <= 1'b1;
                    state_q    <= StStart;
                end
                StStart: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (done_flag) begin
                        m_valid_q  <= 1'b1;
                        m_result_q <= result;
                        m_err_q    <= err_ovf_q;
                        state_q    <= StResp;
                    end else if (tmo_expired) begin
                        m_valid_q  <= 1'b1;
                        m_result_q <= '0;
                        m_err_q    <= 1'b1;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (m_ready) begin
                        m_valid_q  <= 1'b0;
                        m_result_q <= '0;
                        m_err_q    <= 1'b0;
                        count_q    <= '0;
                        err_ovf_q  <= 1'b0;
                        n_q        <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // s_ready depends on state only; forced low while reset is asserted
    always_comb begin
        s_ready = !rst && load_state;
    end

    assign ram_init  = ram_init_q;
    assign a_ram_in  = a_ram_q;
    assign b_ram_in  = b_ram_q;
    assign a_addr_in = addr_q;
    assign b_addr_in = addr_q;
    assign start_sig = start_q;
    assign n         = n_q;
    assign m_valid   = m_valid_q;
    assign m_result  = m_result_q;
    assign m_err     = m_err_q;

endmodule

// File: tb/tb_vec_loader.sv
// Self-checking bench for vec_loader: table of vector loads with random data,
// a falling-edge RAM model plus engine model, and hand-written corner sequences.
module tb_vec_loader;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam int unsigned TIMEOUT_CYC = 50;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              s_last;
    logic              ram_init;
    logic [DATA_W-1:0] a_ram_in;
    logic [DATA_W-1:0] b_ram_in;
    logic [ADDR_W-1:0] a_addr_in;
    logic [ADDR_W-1:0] b_addr_in;
    logic              start_sig;
    logic [31:0]       n;
    logic [DATA_W-1:0] result;
    logic              done_flag;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_result;
    logic              m_err;

    vec_loader #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .s_last    (s_last),
        .ram_init  (ram_init),
        .a_ram_in  (a_ram_in),
        .b_ram_in  (b_ram_in),
        .a_addr_in (a_addr_in),
        .b_addr_in (b_addr_in),
        .start_sig (start_sig),
        .n         (n),
        .result    (result),
        .done_flag (done_flag),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_result  (m_result),
        .m_err     (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // RAM model written on the falling edge, plus start/address bookkeeping
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    int start_total    = 0;
    int addr_bad_total = 0;

    always @(negedge clk) begin
        if (ram_init === 1'b1) begin
            mem_a[a_addr_in] <= a_ram_in;
            mem_b[b_addr_in] <= b_ram_in;
            if (a_addr_in !== b_addr_in) addr_bad_total <= addr_bad_total + 1;
        end
        if (start_sig === 1'b1) start_total <= start_total + 1;
    end

    // Engine model: dot product over the RAM model, done held for two cycles
    bit engine_on = 1'b1;

    initial begin : engine
        int                lat;
        logic [31:0]       n_seen;
        logic [DATA_W-1:0] acc;
        done_flag = 1'b0;
        result    = '0;
        forever begin
            @(negedge clk);
            if (start_sig === 1'b1 && engine_on) begin
                n_seen = n;
                lat = $urandom_range(0, 4);
                repeat (lat) @(negedge clk);
                acc = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < n_seen) acc += mem_a[i] * mem_b[i];
                end
                result    = acc;
                done_flag = 1'b1;
                repeat (2) @(negedge clk);
                done_flag = 1'b0;
                result    = $urandom;
            end
        end
    end

    logic [DATA_W-1:0] vec_a [32];
    logic [DATA_W-1:0] vec_b [32];

    // Stream vec_a/vec_b, collect the response and compare with the model
    task automatic run_vec(input string tag, input int len, input bit send_last,
                           input bit gaps, input int rdly, input int exp_n,
                           input bit exp_err, input bit timing);
        logic [DATA_W-1:0] model_sum;
        int acc_cnt, budget, start_base, bad_base;
        bit v, rdy, hold_bad;
        model_sum  = '0;
        for (int i = 0; i < exp_n; i++) model_sum += vec_a[i] * vec_b[i];
        acc_cnt    = 0;
        budget     = 0;
        hold_bad   = 1'b0;
        start_base = start_total;
        bad_base   = addr_bad_total;
        while (acc_cnt < len && budget < 400) begin
            v       = !(gaps && ($urandom_range(0, 3) == 0));
            s_valid = v;
            s_a     = vec_a[acc_cnt];
            s_b     = vec_b[acc_cnt];
            s_last  = send_last && (acc_cnt == len - 1);
            rdy     = s_ready;
            @(posedge clk); #1;
            budget++;
            if (v && rdy) acc_cnt++;
            else if (v && acc_cnt > 0) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check({tag, ":accepted"}, acc_cnt, exp_n);
        if (timing) begin
            check({tag, ":drain_s_ready"}, s_ready, 1'b0);
            check({tag, ":drain_ram_init"}, ram_init, 1'b1);
            check({tag, ":drain_start"}, start_sig, 1'b0);
            check({tag, ":drain_n"}, n, exp_n);
            @(posedge clk); #1;
            check({tag, ":start_pulse"}, start_sig, 1'b1);
            check({tag, ":start_ram_init"}, ram_init, 1'b0);
            @(posedge clk); #1;
            check({tag, ":start_low"}, start_sig, 1'b0);
        end
        budget = 0;
        while (m_valid !== 1'b1 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        check({tag, ":m_valid_seen"}, m_valid, 1'b1);
        for (int r = 0; r < rdly; r++) begin
            if (!(m_valid === 1'b1 && m_result === model_sum && s_ready === 1'b0 &&
                  n === exp_n)) hold_bad = 1'b1;
            @(posedge clk); #1;
        end
        if (rdly > 0) check({tag, ":resp_hold"}, hold_bad, 1'b0);
        check({tag, ":m_result"}, m_result, model_sum);
        check({tag, ":m_err"}, m_err, exp_err);
        check({tag, ":n"}, n, exp_n);
        check({tag, ":start_pulses"}, start_total - start_base, 1);
        check({tag, ":addr_equal"}, addr_bad_total - bad_base, 0);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check({tag, ":m_valid_drop"}, m_valid, 1'b0);
        check({tag, ":idle_s_ready"}, s_ready, 1'b1);
    endtask

    typedef struct {
        int len;
        bit last;
        bit gaps;
        int rdly;
        int exp_n;
        bit exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        int cycles;
        tbl[0] = '{len: 4,  last: 1, gaps: 1, rdly: 0,  exp_n: 4,  exp_err: 0};
        tbl[1] = '{len: 7,  last: 1, gaps: 1, rdly: 2,  exp_n: 7,  exp_err: 0};
        tbl[2] = '{len: 3,  last: 1, gaps: 0, rdly: 10, exp_n: 3,  exp_err: 0};
        tbl[3] = '{len: 16, last: 1, gaps: 0, rdly: 1,  exp_n: 16, exp_err: 0};
        tbl[4] = '{len: 16, last: 0, gaps: 1, rdly: 0,  exp_n: 16, exp_err: 1};
        tbl[5] = '{len: 20, last: 0, gaps: 0, rdly: 3,  exp_n: 16, exp_err: 1};
        tbl[6] = '{len: 12, last: 1, gaps: 1, rdly: 0,  exp_n: 12, exp_err: 0};
        tbl[7] = '{len: 1,  last: 1, gaps: 0, rdly: 4,  exp_n: 1,  exp_err: 0};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(posedge clk); #1;
        check("reset:s_ready", s_ready, 1'b0);
        check("reset:ram_init", ram_init, 1'b0);
        check("reset:start_sig", start_sig, 1'b0);
        check("reset:m_valid", m_valid, 1'b0);
        check("reset:n", n, 0);
        check("reset:m_err", m_err, 1'b0);
        check("reset:m_result", m_result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("reset:s_ready_after", s_ready, 1'b1);

        // Basic four-element load with timing of the start pulse
        for (int i = 0; i < 4; i++) begin
            vec_a[i] = 32'(i + 1);
            vec_b[i] = 32'(i + 5);
        end
        run_vec("tp1", 4, 1'b1, 1'b0, 0, 4, 1'b0, 1'b1);

        // Single beat followed back-to-back by random table loads
        vec_a[0] = 32'd7;
        vec_b[0] = 32'd9;
        run_vec("single", 1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) begin
                vec_a[i] = $urandom;
                vec_b[i] = $urandom;
            end
            run_vec($sformatf("tbl%0d", t), tbl[t].len, tbl[t].last, tbl[t].gaps,
                    tbl[t].rdly, tbl[t].exp_n, tbl[t].exp_err, 1'b0);
        end

        // Reset in the middle of a load
        base = start_total;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_a     = $urandom;
            s_b     = $urandom;
            s_last  = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        check("midrst:ram_init", ram_init, 1'b0);
        check("midrst:start_sig", start_sig, 1'b0);
        check("midrst:m_valid", m_valid, 1'b0);
        check("midrst:s_ready_in_reset", s_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst:s_ready_idle", s_ready, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst:no_start", start_total - base, 0);
        for (int i = 0; i < 32; i++) begin
            vec_a[i] = $urandom;
            vec_b[i] = $urandom;
        end
        run_vec("after_rst", 4, 1'b1, 1'b0, 0, 4, 1'b0, 1'b1);

`ifdef VEC_LOADER_TIMEOUT_EN
        // Engine never answers: watchdog must close the transaction
        engine_on = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_a     = $urandom;
            s_b     = $urandom;
            s_last  = (i == 2);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
        check("tmo:start_sig", start_sig, 1'b1);
        cycles = 0;
        while (m_valid !== 1'b1 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("tmo:latency", cycles, TIMEOUT_CYC + 1);
        check("tmo:m_err", m_err, 1'b1);
        check("tmo:m_result", m_result, 0);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("tmo:m_valid_drop", m_valid, 1'b0);
        engine_on = 1'b1;
`else
        cycles = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
